// File: rtl/polybius_decrypt_if.sv
// Byte-stream handshake bundle for the Polybius decoder: valid/ready input
// of codes and a valid/ready output of decoded characters.
interface polybius_decrypt_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_code;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_char;
    logic       out_err;

    modport master (
        output in_valid,
        output in_code,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_char,
        input  out_err
    );

    modport slave (
        input  in_valid,
        input  in_code,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_char,
        output out_err
    );
endinterface

// File: rtl/polybius_decrypt.sv
// Streaming 5x5 Polybius-square decoder (A..Y row-major, Z folded onto Y) with
// a registered, back-pressurable output and saturating good/error counters.
module polybius_decrypt #(
    parameter bit DIGIT_MODE = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    polybius_decrypt_if.slave    bus,
    output logic [15:0]          char_count,
    output logic [15:0]          err_count
);

    typedef enum logic {
        S_ROW = 1'b0,
        S_COL = 1'b1
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [2:0]  row_r, row_nxt_s;
    logic        pair_err_r, pair_err_nxt_s;
    logic        out_valid_r;
    logic [7:0]  out_char_r;
    logic        out_err_r;
    logic [15:0] char_count_r;
    logic [15:0] err_count_r;

    logic        in_ready_s;
    logic        accept_s;
    logic        out_fire_s;
    logic        produce_s;
    logic [7:0]  res_char_s;
    logic        res_err_s;
    logic        is_digit_s;
    logic [7:0]  digit_val_s;
    logic [7:0]  bin_row_s;
    logic [7:0]  bin_col_s;

    // Returns {err, char}; an out-of-grid row or column yields '?'.
    function automatic logic [8:0] decode_rc(input logic [7:0] r, input logic [7:0] c);
        logic [7:0] letter;
        letter = 8'h41 + (8'd5 * (r - 8'd1)) + (c - 8'd1);
        if ((r >= 8'd1) && (r <= 8'd5) && (c >= 8'd1) && (c <= 8'd5)) begin
            decode_rc = {1'b0, letter};
        end else begin
            decode_rc = {1'b1, 8'h3F};
        end
    endfunction

    assign in_ready_s   = !out_valid_r || bus.out_ready;
    assign accept_s     = bus.in_valid && in_ready_s;
    assign out_fire_s   = out_valid_r && bus.out_ready;
    assign is_digit_s   = (bus.in_code >= 8'h31) && (bus.in_code <= 8'h35);
    assign digit_val_s  = bus.in_code - 8'h30;
    assign bin_row_s    = bus.in_code / 8'd10;
    assign bin_col_s    = bus.in_code % 8'd10;

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_char  = out_char_r;
    assign bus.out_err   = out_err_r;
    assign char_count    = char_count_r;
    assign err_count     = err_count_r;

    // Next-state and result decode for both input formats.
    always_comb begin
        state_nxt_s    = state_r;
        row_nxt_s      = row_r;
        pair_err_nxt_s = pair_err_r;
        produce_s      = 1'b0;
        res_char_s     = 8'h00;
        res_err_s      = 1'b0;
        if (!accept_s) begin
            produce_s = 1'b0;
        end else if (DIGIT_MODE == 1'b0) begin
            produce_s               = 1'b1;
            {res_err_s, res_char_s} = decode_rc(bin_row_s, bin_col_s);
        end else begin
            case (state_r)
                S_ROW: begin
                    if (is_digit_s) begin
                        row_nxt_s      = digit_val_s[2:0];
                        pair_err_nxt_s = 1'b0;
                        state_nxt_s    = S_COL;
                    end else if (bus.in_code == 8'h20) begin
                        produce_s  = 1'b1;
                        res_char_s = 8'h20;
                        res_err_s  = 1'b0;
                    end else begin
                        pair_err_nxt_s = 1'b1;
                        state_nxt_s    = S_COL;
                    end
                end
                S_COL: begin
                    produce_s   = 1'b1;
                    state_nxt_s = S_ROW;
                    if (is_digit_s && !pair_err_r) begin
                        {res_err_s, res_char_s} = decode_rc({5'd0, row_r}, digit_val_s);
                    end else begin
                        res_char_s = 8'h3F;
                        res_err_s  = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = S_ROW;
                end
            endcase
        end
    end

    // Pair-assembly state for digit-character input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_ROW;
            row_r      <= 3'd0;
            pair_err_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            row_r      <= row_nxt_s;
            pair_err_r <= pair_err_nxt_s;
        end
    end

    // Output register: a new result overwrites even while the old one is handed off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_char_r  <= 8'h00;
            out_err_r   <= 1'b0;
        end else if (produce_s) begin
            out_valid_r <= 1'b1;
            out_char_r  <= res_char_s;
            out_err_r   <= res_err_s;
        end else if (out_fire_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Saturating counters, stepped when downstream takes a result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_count_r <= 16'd0;
            err_count_r  <= 16'd0;
        end else if (out_fire_s && out_err_r) begin
            if (err_count_r != 16'hFFFF) begin
                err_count_r <= err_count_r + 16'd1;
            end else begin
                err_count_r <= err_count_r;
            end
        end else if (out_fire_s) begin
            if (char_count_r != 16'hFFFF) begin
                char_count_r <= char_count_r + 16'd1;
            end else begin
                char_count_r <= char_count_r;
            end
        end else begin
            char_count_r <= char_count_r;
            err_count_r  <= err_count_r;
        end
    end

endmodule

// File: tb/tb_polybius_decrypt.sv
// Directed bench for polybius_decrypt: one instance per input format, driven
// and sampled on the falling clock edge.
module tb_polybius_decrypt;

    logic        clk;
    logic        rst_n;
    logic [15:0] cc0, ec0, cc1, ec1;
    int          checks;
    int          errors;

    polybius_decrypt_if if0 ();
    polybius_decrypt_if if1 ();

    polybius_decrypt #(.DIGIT_MODE(1'b0)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (if0.slave),
        .char_count (cc0),
        .err_count  (ec0)
    );

    polybius_decrypt #(.DIGIT_MODE(1'b1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (if1.slave),
        .char_count (cc1),
        .err_count  (ec1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        if0.in_valid = 1'b0; if0.in_code = 8'h00; if0.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.in_code = 8'h00; if1.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ((if0.out_valid !== 1'b0) || (if0.out_char !== 8'h00) || (if0.out_err !== 1'b0)) begin
            errors++;
            $display("FAIL reset_out0: got v=%b c=%h e=%b want 0 00 0", if0.out_valid, if0.out_char, if0.out_err);
        end
        checks++;
        if ((if1.out_valid !== 1'b0) || (cc0 !== 16'd0) || (ec0 !== 16'd0) || (cc1 !== 16'd0) || (ec1 !== 16'd0)) begin
            errors++;
            $display("FAIL reset_counts: got v1=%b cc0=%0d ec0=%0d cc1=%0d ec1=%0d want all 0", if1.out_valid, cc0, ec0, cc1, ec1);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ((if0.in_ready !== 1'b1) || (if1.in_ready !== 1'b1)) begin
            errors++;
            $display("FAIL reset_in_ready: got %b %b want 1 1", if0.in_ready, if1.in_ready);
        end
    endtask

    task automatic test_mode0_valid();
        logic [7:0] codes [4] = '{8'd11, 8'd34, 8'd55, 8'd15};
        logic [7:0] exp   [4] = '{8'h41, 8'h4E, 8'h59, 8'h45};
        for (int i = 0; i < 4; i++) begin
            if0.in_code = codes[i]; if0.in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if ((if0.out_valid !== 1'b1) || (if0.out_char !== exp[i]) || (if0.out_err !== 1'b0)) begin
                errors++;
                $display("FAIL m0_code_%0d: got v=%b c=%h e=%b want 1 %h 0", codes[i], if0.out_valid, if0.out_char, if0.out_err, exp[i]);
            end
        end
        if0.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ((if0.out_valid !== 1'b0) || (cc0 !== 16'd4) || (ec0 !== 16'd0)) begin
            errors++;
            $display("FAIL m0_valid_counts: got v=%b cc=%0d ec=%0d want 0 4 0", if0.out_valid, cc0, ec0);
        end
    endtask

    task automatic test_mode0_errors();
        logic [7:0] codes [4] = '{8'd26, 8'd60, 8'd0, 8'd10};
        for (int i = 0; i < 4; i++) begin
            if0.in_code = codes[i]; if0.in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if ((if0.out_valid !== 1'b1) || (if0.out_char !== 8'h3F) || (if0.out_err !== 1'b1)) begin
                errors++;
                $display("FAIL m0_err_code_%0d: got v=%b c=%h e=%b want 1 3f 1", codes[i], if0.out_valid, if0.out_char, if0.out_err);
            end
        end
        if0.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ((cc0 !== 16'd4) || (ec0 !== 16'd4)) begin
            errors++;
            $display("FAIL m0_err_counts: got cc=%0d ec=%0d want 4 4", cc0, ec0);
        end
    endtask

    task automatic test_mode1_pairs();
        logic [7:0] bytes [5] = '{8'h34, 8'h33, 8'h20, 8'h31, 8'h31};
        logic       ev    [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [7:0] ec    [5] = '{8'h00, 8'h52, 8'h20, 8'h00, 8'h41};
        for (int i = 0; i < 5; i++) begin
            if1.in_code = bytes[i]; if1.in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if ((if1.out_valid !== ev[i]) || (ev[i] && ((if1.out_char !== ec[i]) || (if1.out_err !== 1'b0)))) begin
                errors++;
                $display("FAIL m1_pair_step_%0d: got v=%b c=%h e=%b want v=%b c=%h e=0", i, if1.out_valid, if1.out_char, if1.out_err, ev[i], ec[i]);
            end
        end
        if1.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ((if1.out_valid !== 1'b0) || (cc1 !== 16'd3) || (ec1 !== 16'd0)) begin
            errors++;
            $display("FAIL m1_pair_counts: got v=%b cc=%0d ec=%0d want 0 3 0", if1.out_valid, cc1, ec1);
        end
    endtask

    task automatic test_mode1_errors();
        logic [7:0] bytes [6] = '{8'h37, 8'h32, 8'h33, 8'h20, 8'h35, 8'h35};
        logic       ev    [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] ec    [6] = '{8'h00, 8'h3F, 8'h00, 8'h3F, 8'h00, 8'h59};
        logic       ee    [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            if1.in_code = bytes[i]; if1.in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if ((if1.out_valid !== ev[i]) || (ev[i] && ((if1.out_char !== ec[i]) || (if1.out_err !== ee[i])))) begin
                errors++;
                $display("FAIL m1_err_step_%0d: got v=%b c=%h e=%b want v=%b c=%h e=%b", i, if1.out_valid, if1.out_char, if1.out_err, ev[i], ec[i], ee[i]);
            end
        end
        if1.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ((cc1 !== 16'd4) || (ec1 !== 16'd2)) begin
            errors++;
            $display("FAIL m1_err_counts: got cc=%0d ec=%0d want 4 2", cc1, ec1);
        end
    endtask

    task automatic test_back_pressure();
        if0.out_ready = 1'b0;
        if0.in_code = 8'd22; if0.in_valid = 1'b1;
        @(negedge clk);
        if0.in_code = 8'd33;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ((if0.out_valid !== 1'b1) || (if0.out_char !== 8'h47) || (if0.in_ready !== 1'b0) || (cc0 !== 16'd4)) begin
                errors++;
                $display("FAIL bp_hold_%0d: got v=%b c=%h rdy=%b cc=%0d want 1 47 0 4", i, if0.out_valid, if0.out_char, if0.in_ready, cc0);
            end
            @(negedge clk);
        end
        if0.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ((if0.out_valid !== 1'b1) || (if0.out_char !== 8'h4D) || (cc0 !== 16'd5)) begin
            errors++;
            $display("FAIL bp_release: got v=%b c=%h cc=%0d want 1 4d 5", if0.out_valid, if0.out_char, cc0);
        end
        if0.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ((if0.out_valid !== 1'b0) || (cc0 !== 16'd6) || (ec0 !== 16'd4)) begin
            errors++;
            $display("FAIL bp_drain: got v=%b cc=%0d ec=%0d want 0 6 4", if0.out_valid, cc0, ec0);
        end
    endtask

    task automatic test_reset_mid_pair();
        if1.in_code = 8'h32; if1.in_valid = 1'b1;
        @(negedge clk);
        if1.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ((if1.out_valid !== 1'b0) || (cc1 !== 16'd0) || (ec1 !== 16'd0)) begin
            errors++;
            $display("FAIL rst_mid_clear: got v=%b cc=%0d ec=%0d want 0 0 0", if1.out_valid, cc1, ec1);
        end
        if1.in_code = 8'h33; if1.in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (if1.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_first_digit: got v=%b want 0", if1.out_valid);
        end
        if1.in_code = 8'h31;
        @(negedge clk);
        checks++;
        if ((if1.out_valid !== 1'b1) || (if1.out_char !== 8'h4B) || (if1.out_err !== 1'b0)) begin
            errors++;
            $display("FAIL rst_mid_letter: got v=%b c=%h e=%b want 1 4b 0", if1.out_valid, if1.out_char, if1.out_err);
        end
        if1.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ((if1.out_valid !== 1'b0) || (cc1 !== 16'd1) || (ec1 !== 16'd0)) begin
            errors++;
            $display("FAIL rst_mid_counts: got v=%b cc=%0d ec=%0d want 0 1 0", if1.out_valid, cc1, ec1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mode0_valid();
        test_mode0_errors();
        test_mode1_pairs();
        test_mode1_errors();
        test_back_pressure();
        test_reset_mid_pair();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
